// File: rtl/lr_pkg.sv
// Shared types and constants for the leaky-ReLU backward column slice.
// Q8.8 signed fixed point: 8 integer bits (including sign), 8 fraction bits.
package lr_pkg;

  typedef logic signed [15:0] q8_8_t;

  localparam q8_8_t Q8_8_ONE               = 16'sh0100;
  localparam int    LR_CACHE_DEPTH_DEFAULT = 16;

endpackage

// File: rtl/fxp_mul.sv
// Q8.8 x Q8.8 -> Q8.8 signed multiplier, combinational.
// The full product is shifted right arithmetically by the fraction width,
// which truncates toward minus infinity, then saturated to the Q8.8 range.
module fxp_mul
  import lr_pkg::*;
(
  input  q8_8_t a,
  input  q8_8_t b,
  output q8_8_t p
);

  localparam int FRAC_BITS = $clog2(Q8_8_ONE);

  logic signed [31:0] prod;
  logic signed [31:0] shr;

  // Full-width product, rescale, then clamp to the representable range.
  always_comb begin
    prod = 32'(a) * 32'(b);
    shr  = prod >>> FRAC_BITS;
    if (shr > 32'sd32767) begin
      p = 16'sh7FFF;
    end else if (shr < -32'sd32768) begin
      p = 16'sh8000;
    end else begin
      p = shr[15:0];
    end
  end

endmodule

// File: rtl/lr_h_cache.sv
// In-order cache of forward-pass pre-activations (H), one per column.
// Push when not full or when a pop frees a slot in the same cycle; pop when
// not empty (no bypass of a same-cycle push). Flush wins over push and pop.
// Count, full and empty are registered and describe the post-edge state.
module lr_h_cache
  import lr_pkg::*;
#(
  parameter int DEPTH = LR_CACHE_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push_req,
  input  q8_8_t                  push_data,
  input  logic                   pop_req,
  input  logic                   flush,
  output q8_8_t                  head_data,
  output logic                   pop_ok,
  output logic                   overflow_evt,
  output logic                   underflow_evt,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  q8_8_t           mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   count_next;
  logic            push_ok;

  // A flushed cycle neither moves data nor counts as an overflow/underflow.
  assign pop_ok        = pop_req && !empty && !flush;
  assign push_ok       = push_req && (!full || pop_ok) && !flush;
  assign overflow_evt  = push_req && full && !pop_ok && !flush;
  assign underflow_evt = pop_req && empty && !flush;
  assign head_data     = mem[rd_ptr];

  // Occupancy after this edge, used for the registered status flags.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    count_next = count;
    case ({push_ok, pop_ok})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  // Storage write port.
  // NOTE: the array is deliberately not reset; pointers and count define validity.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= push_data;
    end
  end

  // Pointers, occupancy and status flags; pointers wrap modulo DEPTH.
  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
      empty <= (count_next == '0);
    end
  end

endmodule

// File: rtl/leaky_relu_bwd_child.sv
// Leaky-ReLU backward stage for one systolic-array column.
// Caches H during the forward phase; each incoming gradient pops the oldest H
// and yields dL/dH = grad (H >= 0) or fxp_mul(grad, leak) (H < 0), one cycle later.
// Optional macro LRB_STICKY_ERR_EN: error outputs become sticky flags cleared by
// err_clear_in (set wins); otherwise they are one-cycle pulses.
module leaky_relu_bwd_child
  import lr_pkg::*;
#(
  parameter int DEPTH = LR_CACHE_DEPTH_DEFAULT
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   h_valid_in,
  input  q8_8_t                  h_data_in,
  input  logic                   grad_valid_in,
  input  q8_8_t                  grad_data_in,
  input  q8_8_t                  leak_factor_in,
  input  logic                   flush_in,
  input  logic                   err_clear_in,
  output q8_8_t                  grad_data_out,
  output logic                   grad_valid_out,
  output logic [$clog2(DEPTH):0] cache_count_out,
  output logic                   cache_full_out,
  output logic                   cache_empty_out,
  output logic                   err_overflow_out,
  output logic                   err_underflow_out
);

  q8_8_t head_h;
  q8_8_t scaled_grad;
  logic  pop_ok;
  logic  overflow_evt;
  logic  underflow_evt;

  lr_h_cache #(.DEPTH(DEPTH)) u_cache (
    .clk           (clk),
    .rst           (rst),
    .push_req      (h_valid_in),
    .push_data     (h_data_in),
    .pop_req       (grad_valid_in),
    .flush         (flush_in),
    .head_data     (head_h),
    .pop_ok        (pop_ok),
    .overflow_evt  (overflow_evt),
    .underflow_evt (underflow_evt),
    .count         (cache_count_out),
    .full          (cache_full_out),
    .empty         (cache_empty_out)
  );

  fxp_mul u_mul (
    .a (grad_data_in),
    .b (leak_factor_in),
    .p (scaled_grad)
  );

  // Registered gradient output: sign of the popped H selects pass-through or leak.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      grad_valid_out <= 1'b0;
      grad_data_out  <= '0;
    end else if (pop_ok) begin
      grad_valid_out <= 1'b1;
      grad_data_out  <= head_h[15] ? scaled_grad : grad_data_in;
    end else begin
      grad_valid_out <= 1'b0;
      grad_data_out  <= '0;
    end
  end

`ifdef LRB_STICKY_ERR_EN
  // Sticky error flags: a new event in the clearing cycle keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow_out  <= 1'b0;
      err_underflow_out <= 1'b0;
    end else begin
      if (overflow_evt)      err_overflow_out  <= 1'b1;
      else if (err_clear_in) err_overflow_out  <= 1'b0;
      if (underflow_evt)     err_underflow_out <= 1'b1;
      else if (err_clear_in) err_underflow_out <= 1'b0;
    end
  end
`else
  // Error outputs are single-cycle pulses following each event.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_overflow_out  <= 1'b0;
      err_underflow_out <= 1'b0;
    end else begin
      err_overflow_out  <= overflow_evt;
      err_underflow_out <= underflow_evt;
    end
  end

  logic unused_err_clear;
  assign unused_err_clear = err_clear_in;
`endif

endmodule
